fetch_stage: RTL and testbench

- IF stage plus the IF/ID pipeline register of the 5-stage pipelined MIPS CPU.
- Holds PCF and issues instruction-memory requests over a ready-qualified handshake.
- Applies the hazard unit's StallF/StallD and Decode-stage redirects (branch/jump), and delivers InstrD/PCPlus4D to Decode.
- Includes a one-entry hold buffer, so an instruction returned while the pipe is stalled is neither lost nor refetched.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/ifid_reg.sv | 34 +++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the pipelined MIPS CPU slice.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = '0;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = '0;

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetchState_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load enable, synchronous clear to a bubble, async reset.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcPlus4In,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (clr) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (en) begin
            InstrD   <= instrIn;
            PCPlus4D <= pcPlus4In;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, ready-qualified imem handshake, one-entry hold buffer, IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchMissCnt
);

    fetchState_t       state, stateNext;
    logic [WORD_W-1:0] pcF, pcNext, pcPlus4F;
    logic [WORD_W-1:0] bufInstr, bufPcPlus4;
    logic              bufLoad, ifidLoad, ifidClear, missInc;
    logic [WORD_W-1:0] ifidInstr, ifidPcPlus4;
    logic              adv, redirect;
    logic [WORD_W-1:0] target;

    assign adv       = !StallF && !StallD;
    assign redirect  = (PCSrcD || JumpD) && !StallD;
    assign target    = JumpD ? PCJumpD : PCBranchD;
    assign pcPlus4F  = pcF + 32'd4;
    assign imem_req  = (state == FETCH) && !reset;
    assign imem_addr = pcF;

    always_comb begin
        stateNext   = state;
        pcNext      = pcF;
        bufLoad     = 1'b0;
        ifidLoad    = 1'b0;
        ifidClear   = 1'b0;
        missInc     = 1'b0;
        ifidInstr   = imem_rdata;
        ifidPcPlus4 = pcPlus4F;
        if (redirect) begin
            // Wrong-path fetch is squashed; leaving HELD discards the buffer.
            pcNext    = target;
            stateNext = FETCH;
            ifidClear = 1'b1;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (adv) begin
                            ifidLoad = 1'b1;
                            pcNext   = pcPlus4F;
                        end else begin
                            bufLoad   = 1'b1;
                            stateNext = HELD;
                        end
                    end else if (!StallD) begin
                        ifidClear = 1'b1;
                        missInc   = 1'b1;
                    end
                end
                HELD: begin
                    if (adv) begin
                        ifidLoad    = 1'b1;
                        ifidInstr   = bufInstr;
                        ifidPcPlus4 = bufPcPlus4;
                        pcNext      = pcPlus4F;
                        stateNext   = FETCH;
                    end
                end
                default: stateNext = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            pcF          <= RESET_PC;
            bufInstr     <= '0;
            bufPcPlus4   <= '0;
            FetchMissCnt <= '0;
        end else begin
            state <= stateNext;
            pcF   <= pcNext;
            if (bufLoad) begin
                bufInstr   <= imem_rdata;
                bufPcPlus4 <= pcPlus4F;
            end
            if (missInc)
                FetchMissCnt <= FetchMissCnt + 32'd1;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) uIfid (
        .clk       (clk),
        .reset     (reset),
        .en        (ifidLoad),
        .clr       (ifidClear),
        .instrIn   (ifidInstr),
        .pcPlus4In (ifidPcPlus4),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with a zero-wait instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic [31:0] InstrD, PCPlus4D, FetchMissCnt;
    logic        ValidD;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .PCSrcD       (PCSrcD),
        .JumpD        (JumpD),
        .PCBranchD    (PCBranchD),
        .PCJumpD      (PCJumpD),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .InstrD       (InstrD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD),
        .FetchMissCnt (FetchMissCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkIfid(input string tag, input logic [31:0] addr,
                           input logic [31:0] instr, input logic [31:0] pc4,
                           input logic valid);
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".instr"}, InstrD, instr);
        chk({tag, ".pc4"},   PCPlus4D, pc4);
        chk({tag, ".valid"}, {31'd0, ValidD}, {31'd0, valid});
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        PCBranchD = '0; PCJumpD = '0; imem_ready = 1'b1;
        #1;
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.miss", FetchMissCnt, 32'd0);
        chkIfid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        #11 reset = 1'b0;

        // Streaming fetch: one instruction per cycle, one-cycle latency
        tick(); chkIfid("s0", 32'h04, memWord(32'h00), 32'h04, 1'b1);
        chk("s0.req", {31'd0, imem_req}, 32'd1);
        tick(); chkIfid("s1", 32'h08, memWord(32'h04), 32'h08, 1'b1);
        tick(); chkIfid("s2", 32'h0C, memWord(32'h08), 32'h0C, 1'b1);
        tick(); chkIfid("s3", 32'h10, memWord(32'h0C), 32'h10, 1'b1);

        // Three fetch misses at 0x10
        imem_ready = 1'b0;
        tick(); chkIfid("m0", 32'h10, 32'h0, 32'h0, 1'b0);
        tick(); chkIfid("m1", 32'h10, 32'h0, 32'h0, 1'b0);
        tick(); chkIfid("m2", 32'h10, 32'h0, 32'h0, 1'b0);
        chk("m.cnt", FetchMissCnt, 32'd3);
        chk("m.req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        tick(); chkIfid("m3", 32'h14, memWord(32'h10), 32'h14, 1'b1);
        tick(); chkIfid("m4", 32'h18, memWord(32'h14), 32'h18, 1'b1);
        tick(); chkIfid("m5", 32'h1C, memWord(32'h18), 32'h1C, 1'b1);
        tick(); chkIfid("m6", 32'h20, memWord(32'h1C), 32'h20, 1'b1);

        // Stall while ready at 0x20: word captured in hold buffer
        StallF = 1'b1; StallD = 1'b1;
        tick(); chkIfid("h0", 32'h20, memWord(32'h1C), 32'h20, 1'b1);
        chk("h0.req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b0;
        tick(); chkIfid("h1", 32'h20, memWord(32'h1C), 32'h20, 1'b1);
        chk("h1.req", {31'd0, imem_req}, 32'd0);
        StallF = 1'b0; StallD = 1'b0;
        tick(); chkIfid("h2", 32'h24, memWord(32'h20), 32'h24, 1'b1);
        chk("h2.req", {31'd0, imem_req}, 32'd1);
        chk("h2.cnt", FetchMissCnt, 32'd3);
        imem_ready = 1'b1;
        tick(); chkIfid("h3", 32'h28, memWord(32'h24), 32'h28, 1'b1);
        tick(); chkIfid("h4", 32'h2C, memWord(32'h28), 32'h2C, 1'b1);
        tick(); chkIfid("h5", 32'h30, memWord(32'h2C), 32'h30, 1'b1);

        // Taken branch at 0x30 squashes the wrong-path fetch
        PCSrcD = 1'b1; PCBranchD = 32'h100;
        tick(); chkIfid("b0", 32'h100, 32'h0, 32'h0, 1'b0);
        PCSrcD = 1'b0;
        tick(); chkIfid("b1", 32'h104, memWord(32'h100), 32'h104, 1'b1);

        // Branch blocked by StallD, taken once the stall clears
        PCSrcD = 1'b1; PCBranchD = 32'h200; StallF = 1'b1; StallD = 1'b1;
        tick(); chkIfid("bs0", 32'h104, memWord(32'h100), 32'h104, 1'b1);
        chk("bs0.req", {31'd0, imem_req}, 32'd0);
        StallF = 1'b0; StallD = 1'b0;
        tick(); chkIfid("bs1", 32'h200, 32'h0, 32'h0, 1'b0);
        PCSrcD = 1'b0;
        tick(); chkIfid("bs2", 32'h204, memWord(32'h200), 32'h204, 1'b1);

        // Jump has priority over branch
        JumpD = 1'b1; PCSrcD = 1'b1; PCJumpD = 32'h300; PCBranchD = 32'h400;
        tick(); chkIfid("j0", 32'h300, 32'h0, 32'h0, 1'b0);
        JumpD = 1'b0; PCSrcD = 1'b0;
        tick(); chkIfid("j1", 32'h304, memWord(32'h300), 32'h304, 1'b1);

        // PC wrap at the top of the address space
        JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC;
        tick(); chkIfid("w0", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        JumpD = 1'b0;
        tick(); chkIfid("w1", 32'h0, memWord(32'hFFFF_FFFC), 32'h0, 1'b1);
        tick(); chkIfid("w2", 32'h4, memWord(32'h0), 32'h4, 1'b1);

        // Asynchronous reset while HELD
        StallF = 1'b1; StallD = 1'b1;
        tick(); chk("ar.req0", {31'd0, imem_req}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chkIfid("ar", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("ar.req", {31'd0, imem_req}, 32'd0);
        chk("ar.cnt", FetchMissCnt, 32'd0);
        StallF = 1'b0; StallD = 1'b0;
        #2 reset = 1'b0;
        #1 chk("ar.req1", {31'd0, imem_req}, 32'd1);
        tick(); chkIfid("ar1", 32'h4, memWord(32'h0), 32'h4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
